comar_xor_sched: RTL and testbench
==================================

// Module: comar_xor_sched
// PURPOSE
//  Round-robin scheduler sharing one 2-share COMAR XOR gadget (2-cycle latency) among NREQ requesters.
//  Fetches 6-bit fresh-mask words from a PRNG over a valid/ready handshake.
//  Reuses each mask word for REUSE operations.
//  Aligns mask bits to the gadget pipeline: r[1:0] in the issue cycle, r[5:2] one cycle later.
//  Returns each result tagged with the requester id. Sits between operand producers and the gadget instance.
// PARAMETERS
//  NREQ   4  number of requesters (2..8); IDW = $clog2(NREQ)
//  REUSE  2  operations served per mask word (1..15)
// PORTS
//  clk          in   1        clock; all state on rising edge
//  rst_n        in   1        synchronous reset, active-low
//  req_valid    in   NREQ     requester i has an operand pair
//  req_a        in   2*NREQ   shares of a, requester i at [2i+1:2i]
//  req_b        in   2*NREQ   shares of b, same packing
//  req_ready    out  NREQ     one-hot grant; transfer when req_valid[i]&req_ready[i]
//  prng_valid   in   1        mask word available
//  prng_data    in   6        fresh-mask word
//  prng_ready   out  1        scheduler accepts mask word
//  common_share in   1        shared output share for this issue
//  g_a, g_b     out  2 each   operands to gadget (registered)
//  g_r          out  6        masks to gadget
//  g_common     out  1        to gadget common_out
//  g_c          in   2        gadget result
//  rsp_valid    out  1        result valid
//  rsp_id       out  IDW      requester index of result
//  rsp_c        out  2        result shares (= g_c when rsp_valid)
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=EMPTY, use_cnt=0, rr_ptr=0, pipeline valids cleared.
//   All outputs 0, including in-flight ops: dropped, no rsp. Mask regs cleared to 0.
//  FSM EMPTY: prng_ready=1, req_ready=0.
//   On prng_valid: mask<=prng_data, use_cnt<=0, ->ARMED.
//  FSM ARMED: prng_ready=0.
//   Grant = first i with req_valid[i], searching from rr_ptr upward, modulo NREQ.
//   req_ready is one-hot for that i (combinational from req_valid); 0 if none valid.
//   On issue: rr_ptr<=i+1 mod NREQ, use_cnt++.
//   If use_cnt==REUSE-1 at issue: ->EMPTY, next mask fetch may start the following cycle.
//  Issue cycle t (handshake at edge t):
//   g_a,g_b<=operands and g_common pipeline loaded.
//   Gadget sees g_a/g_b and g_r[1:0]=mask[1:0] during t+1.
//  Mask alignment: g_r[1:0] = mask word of op in gadget stage 0.
//   g_r[5:2] = word of op in stage 1 (one-cycle delayed copy).
//   Back-to-back issues across a mask change therefore present mixed words.
//   g_r is held at last values when stage empty.
//  g_common = common_share sampled at issue, delayed to align with stage 2 (gadget output cycle).
//  Latency: rsp_valid=1 at t+3 (1 operand reg + 2 gadget regs), rsp_id=granted index, rsp_c=g_c.
//  Throughput 1 op/cycle while ARMED; no rsp backpressure (fixed latency, consumer must accept).
//  Mask exhaustion: 1 idle cycle minimum (EMPTY) between words; prng_valid low holds EMPTY indefinitely.
//  Simultaneous prng_valid and req_valid in EMPTY: mask accepted only; request waits one cycle.
//  Inputs req_a/req_b may change while not granted; only granted data is sampled.
// TESTING
//  1. rst_n=0 2 cycles, all req_valid=1, prng_valid=1 -> all outputs 0.
//     After release: prng_ready=1 cycle 1, first grant req 0 cycle 2.
//  2. NREQ=4, REUSE=2, all req_valid=1, prng_valid=1 always:
//     grants 0,1,-,2,3,-,0 (- = EMPTY fetch).
//     rsp_id sequence matches, each 3 cycles after grant.
//  3. prng_data=6'h2A then 6'h15, back-to-back issues straddling the change:
//     cycle with g_r[1:0]=2'b01 has g_r[5:2]=4'b1010.
//  4. Single req 2: a=2'b10, b=2'b01, g_c driven 2'b11 at t+3
//     -> rsp_valid=1, rsp_id=2, rsp_c=2'b11 exactly once.
//  5. Reset asserted at t+1 of an issue -> no rsp_valid afterwards; state EMPTY, rr_ptr=0.
//  6. prng_valid=0 for 20 cycles with requests pending -> req_ready=0 throughout, no rsp.

Source files
------------

// File: rtl/comar_xor_sched_if.sv
// =====================================================================
// comar_xor_sched_if : requester, PRNG, gadget and response bundle
// Rev 1.0
// =====================================================================
`default_nettype none

interface comar_xor_sched_if #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]   req_valid;
    logic [2*NREQ-1:0] req_a;
    logic [2*NREQ-1:0] req_b;
    logic [NREQ-1:0]   req_ready;

    logic              prng_valid;
    logic [5:0]        prng_data;
    logic              prng_ready;

    logic              common_share;

    logic [1:0]        g_a;
    logic [1:0]        g_b;
    logic [5:0]        g_r;
    logic              g_common;
    logic [1:0]        g_c;

    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [1:0]        rsp_c;

    // master: requesters, PRNG and gadget environment; slave: the scheduler
    modport master (
        output req_valid, req_a, req_b, prng_valid, prng_data, common_share, g_c,
        input  req_ready, prng_ready, g_a, g_b, g_r, g_common, rsp_valid, rsp_id, rsp_c
    );

    modport slave (
        input  req_valid, req_a, req_b, prng_valid, prng_data, common_share, g_c,
        output req_ready, prng_ready, g_a, g_b, g_r, g_common, rsp_valid, rsp_id, rsp_c
    );
endinterface

`default_nettype wire

// File: rtl/comar_xor_sched.sv
// =====================================================================
// comar_xor_sched : round-robin sharing of one 2-cycle COMAR XOR gadget
// Rev 1.0
// =====================================================================
`default_nettype none

module comar_xor_sched #(
    parameter int NREQ  = 4,
    parameter int REUSE = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    comar_xor_sched_if.slave  bus
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

    state_t         state_q;
    logic [5:0]     mask_q;
    logic [3:0]     use_cnt_q;
    logic [IDW-1:0] rr_ptr_q;

    logic [NREQ-1:0] grant_oh;
    logic [IDW-1:0]  grant_idx;
    logic [IDW-1:0]  scan_idx;
    logic            grant_any;
    logic            issue;

    logic            v1_q, v2_q, v3_q;
    logic [IDW-1:0]  id1_q, id2_q, id3_q;
    logic [1:0]      ga_q, gb_q;
    logic [1:0]      r_lo_q;
    logic [3:0]      r_hi_q;
    logic [3:0]      m_hi1_q;
    logic            c1_q, c2_q, gcom_q;

    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return IDW'(s);
    endfunction

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        grant_oh  = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = wrap_idx(rr_ptr_q, k);
            if (!grant_any && bus.req_valid[scan_idx]) begin
                grant_any = 1'b1;
                grant_idx = scan_idx;
            end
        end
        if (state_q == ST_ARMED && grant_any) grant_oh[grant_idx] = 1'b1;
    end

    assign issue          = (state_q == ST_ARMED) && grant_any;
    assign bus.req_ready  = grant_oh;
    // Held low while reset is asserted so every output reads 0 during reset
    assign bus.prng_ready = (state_q == ST_EMPTY) && rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_EMPTY;
            mask_q    <= '0;
            use_cnt_q <= '0;
            rr_ptr_q  <= '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (bus.prng_valid) begin
                        mask_q    <= bus.prng_data;
                        use_cnt_q <= '0;
                        state_q   <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (issue) begin
                        rr_ptr_q  <= wrap_idx(grant_idx, 1);
                        use_cnt_q <= use_cnt_q + 4'd1;
                        if (use_cnt_q == 4'(REUSE - 1)) state_q <= ST_EMPTY;
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

    // Stage 0 = operand register; r[5:2] follows the op into gadget stage 1
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            id1_q   <= '0;
            id2_q   <= '0;
            id3_q   <= '0;
            ga_q    <= '0;
            gb_q    <= '0;
            r_lo_q  <= '0;
            r_hi_q  <= '0;
            m_hi1_q <= '0;
            c1_q    <= 1'b0;
            c2_q    <= 1'b0;
            gcom_q  <= 1'b0;
        end else begin
            v1_q  <= issue;
            v2_q  <= v1_q;
            v3_q  <= v2_q;
            id2_q <= id1_q;
            id3_q <= id2_q;
            c2_q  <= c1_q;
            gcom_q <= c2_q;
            if (issue) begin
                id1_q   <= grant_idx;
                ga_q    <= bus.req_a[{grant_idx, 1'b0} +: 2];
                gb_q    <= bus.req_b[{grant_idx, 1'b0} +: 2];
                r_lo_q  <= mask_q[1:0];
                m_hi1_q <= mask_q[5:2];
                c1_q    <= bus.common_share;
            end
            if (v1_q) r_hi_q <= m_hi1_q;
        end
    end

    assign bus.g_a       = ga_q;
    assign bus.g_b       = gb_q;
    assign bus.g_r       = {r_hi_q, r_lo_q};
    assign bus.g_common  = gcom_q;
    assign bus.rsp_valid = v3_q;
    assign bus.rsp_id    = v3_q ? id3_q : '0;
    assign bus.rsp_c     = v3_q ? bus.g_c : 2'b00;

endmodule

`default_nettype wire

// File: tb/tb_comar_xor_sched.sv
// =====================================================================
// tb_comar_xor_sched : directed self-checking bench for comar_xor_sched
// Rev 1.0
// =====================================================================
`default_nettype none

module tb_comar_xor_sched;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   rsp_cnt;

    logic [3:0] e_rdy  [0:9];
    logic       e_prdy [0:9];
    logic       e_rv   [0:9];
    logic [1:0] e_id   [0:9];
    logic       e_gcom [0:9];
    logic [5:0] e_gr   [0:9];

    comar_xor_sched_if #(.NREQ(4)) bus ();

    comar_xor_sched #(.NREQ(4), .REUSE(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdy"},  8'(bus.req_ready), 8'h00);
        chk({tag, "_prdy"}, 8'(bus.prng_ready), 8'h00);
        chk({tag, "_ga"},   8'(bus.g_a), 8'h00);
        chk({tag, "_gb"},   8'(bus.g_b), 8'h00);
        chk({tag, "_gr"},   8'(bus.g_r), 8'h00);
        chk({tag, "_gcom"}, 8'(bus.g_common), 8'h00);
        chk({tag, "_rv"},   8'(bus.rsp_valid), 8'h00);
        chk({tag, "_rid"},  8'(bus.rsp_id), 8'h00);
        chk({tag, "_rc"},   8'(bus.rsp_c), 8'h00);
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rsp_cnt = 0;
        e_rdy  = '{4'h1, 4'h2, 4'h0, 4'h4, 4'h8, 4'h0, 4'h1, 4'h2, 4'h0, 4'h4};
        e_prdy = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        e_rv   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        e_id   = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd3, 2'd0, 2'd0};
        e_gcom = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        e_gr   = '{6'h00, 6'h02, 6'h2A, 6'h2A, 6'h29, 6'h15, 6'h15, 6'h15, 6'h15, 6'h15};

        // Reset with everything requesting
        rst_n            = 1'b0;
        bus.req_valid    = 4'hF;
        bus.req_a        = 8'b11_10_01_00;
        bus.req_b        = 8'b00_01_10_11;
        bus.prng_valid   = 1'b1;
        bus.prng_data    = 6'h2A;
        bus.common_share = 1'b0;
        bus.g_c          = 2'b10;
        tick();
        tick();
        chk_all_zero("rst");

        // Cycle 1: mask fetch only
        rst_n = 1'b1;
        #1;
        chk("c1_prdy", 8'(bus.prng_ready), 8'h01);
        chk("c1_rdy",  8'(bus.req_ready), 8'h00);
        chk("c1_gr",   8'(bus.g_r), 8'h00);
        tick();
        bus.prng_data = 6'h15;

        // Cycles 2..11: round robin, reuse, mask alignment, response pipe
        for (int i = 0; i < 10; i++) begin
            bus.common_share = (i == 0);
            #1;
            chk($sformatf("c%0d_rdy", i + 2),  8'(bus.req_ready), 8'(e_rdy[i]));
            chk($sformatf("c%0d_prdy", i + 2), 8'(bus.prng_ready), 8'(e_prdy[i]));
            chk($sformatf("c%0d_rv", i + 2),   8'(bus.rsp_valid), 8'(e_rv[i]));
            chk($sformatf("c%0d_rid", i + 2),  8'(bus.rsp_id), 8'(e_id[i]));
            chk($sformatf("c%0d_rc", i + 2),   8'(bus.rsp_c), e_rv[i] ? 8'h02 : 8'h00);
            chk($sformatf("c%0d_gcom", i + 2), 8'(bus.g_common), 8'(e_gcom[i]));
            chk($sformatf("c%0d_gr", i + 2),   8'(bus.g_r), 8'(e_gr[i]));
            if (i == 1) begin
                chk("c3_ga", 8'(bus.g_a), 8'h00);
                chk("c3_gb", 8'(bus.g_b), 8'h03);
            end
            if (i == 2) begin
                chk("c4_ga", 8'(bus.g_a), 8'h01);
                chk("c4_gb", 8'(bus.g_b), 8'h02);
            end
            tick();
        end

        // Cycle 12: op from req 1 returns, then reset one cycle after req 2 issued
        chk("c12_rv",  8'(bus.rsp_valid), 8'h01);
        chk("c12_rid", 8'(bus.rsp_id), 8'h01);
        rst_n = 1'b0;
        tick();
        #1;
        chk("r13_rv",   8'(bus.rsp_valid), 8'h00);
        chk("r13_rdy",  8'(bus.req_ready), 8'h00);
        chk("r13_prdy", 8'(bus.prng_ready), 8'h00);
        rst_n = 1'b1;
        #1;
        chk("r13_prdy_rel", 8'(bus.prng_ready), 8'h01);
        tick();
        #1;
        chk("r14_rv",  8'(bus.rsp_valid), 8'h00);
        chk("r14_rdy", 8'(bus.req_ready), 8'h01);
        bus.req_valid = 4'h0;
        for (int k = 0; k < 3; k++) begin
            tick();
            #1;
            chk($sformatf("r%0d_rv", k + 15), 8'(bus.rsp_valid), 8'h00);
        end

        // Single request from 2 with its own operands
        bus.prng_valid = 1'b0;
        bus.req_a      = 8'b01_10_11_00;
        bus.req_b      = 8'b10_01_00_11;
        bus.g_c        = 2'b11;
        bus.req_valid  = 4'b0100;
        #1;
        chk("s_rdy", 8'(bus.req_ready), 8'h04);
        tick();
        bus.req_valid = 4'h0;
        #1;
        chk("s_ga",  8'(bus.g_a), 8'h02);
        chk("s_gb",  8'(bus.g_b), 8'h01);
        chk("s_rdy0", 8'(bus.req_ready), 8'h00);
        for (int k = 1; k <= 6; k++) begin
            if (bus.rsp_valid === 1'b1) rsp_cnt++;
            if (k == 3) begin
                chk("s_rv",  8'(bus.rsp_valid), 8'h01);
                chk("s_rid", 8'(bus.rsp_id), 8'h02);
                chk("s_rc",  8'(bus.rsp_c), 8'h03);
            end
            tick();
        end
        chk("s_rsp_once", 8'(rsp_cnt), 8'h01);

        // Exhaust the word with req 1 (pointer sits at 3), then starve the PRNG
        bus.req_valid = 4'b0010;
        #1;
        chk("x_rdy", 8'(bus.req_ready), 8'h02);
        tick();
        bus.req_valid = 4'hF;
        for (int k = 1; k <= 20; k++) begin
            #1;
            chk($sformatf("p%0d_rdy", k),  8'(bus.req_ready), 8'h00);
            chk($sformatf("p%0d_prdy", k), 8'(bus.prng_ready), 8'h01);
            chk($sformatf("p%0d_rv", k),   8'(bus.rsp_valid), (k == 3) ? 8'h01 : 8'h00);
            if (k == 3) chk("p3_rid", 8'(bus.rsp_id), 8'h01);
            tick();
        end

        // Mask returns: next grant continues from requester 2
        bus.prng_valid = 1'b1;
        tick();
        bus.prng_valid = 1'b0;
        #1;
        chk("resume_rdy", 8'(bus.req_ready), 8'h04);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

`default_nettype wire
